// File: rtl/de0qsys_button_pio.sv
// de0qsys_button_pio
// Avalon-MM input PIO for the DE0 push-buttons and switches.
// Each raw input goes through a two-flop synchroniser and a per-bit debouncer.
// Edges of the debounced level are latched in EDGECAPTURE.
// A level IRQ is raised for every captured bit that is enabled in IRQMASK.
// Register map (word addresses):
//     0 DATA (RO), 1 reserved (reads 0), 2 IRQMASK (RW), 3 EDGECAPTURE (RW1C).

module de0qsys_button_pio #(
    parameter int               WIDTH        = 4,
    parameter int               DEBOUNCE_CYC = 50000,
    parameter int               EDGE_TYPE    = 2,
    parameter logic [WIDTH-1:0] IN_RST_VAL   = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // The counter needs to hold DEBOUNCE_CYC-1; keep at least one bit so the bypass build still elaborates
    localparam int               CNT_W    = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (DEBOUNCE_CYC > 0) ? CNT_W'(DEBOUNCE_CYC - 1) : '0;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0]            syncMeta_q;
    logic [WIDTH-1:0]            sync_q;
    logic [WIDTH-1:0]            stable_q;
    logic [WIDTH-1:0]            stable_d;
    logic [WIDTH-1:0]            stablePrev_q;
    logic [WIDTH-1:0][CNT_W-1:0] debCnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] debCnt_d;
    logic [WIDTH-1:0]            irqMask_q;
    logic [WIDTH-1:0]            irqMask_d;
    logic [WIDTH-1:0]            edgeCap_q;
    logic [WIDTH-1:0]            edgeCap_d;
    logic [31:0]                 readData_q;
    logic [31:0]                 readData_d;

    logic [WIDTH-1:0]            riseEv;
    logic [WIDTH-1:0]            fallEv;
    logic [WIDTH-1:0]            edgeEv;
    logic [WIDTH-1:0]            clearMask;
    logic                        wrEn;

    // Two-flop synchroniser; the first stage feeds only the second stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncMeta_q <= IN_RST_VAL;
            sync_q     <= IN_RST_VAL;
        end else begin
            syncMeta_q <= in_port;
            sync_q     <= syncMeta_q;
        end
    end

    // Per-bit debounce: a new level is accepted only after DEBOUNCE_CYC consecutive differing cycles
    always_comb begin
        stable_d = stable_q;
        debCnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (DEBOUNCE_CYC == 0) begin
                stable_d[i] = sync_q[i];
            end else if (sync_q[i] != stable_q[i]) begin
                if (debCnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync_q[i];
                end else begin
                    debCnt_d[i] = debCnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounced level, its one-cycle-delayed copy for edge detection, and the counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q     <= IN_RST_VAL;
            stablePrev_q <= IN_RST_VAL;
            debCnt_q     <= '0;
        end else begin
            stable_q     <= stable_d;
            stablePrev_q <= stable_q;
            debCnt_q     <= debCnt_d;
        end
    end

    // Edge selection and register write decode; a fresh event overrides a same-cycle clear
    always_comb begin
        riseEv = stable_q & ~stablePrev_q;
        fallEv = ~stable_q & stablePrev_q;
        case (EDGE_TYPE)
            0:       edgeEv = riseEv;
            1:       edgeEv = fallEv;
            default: edgeEv = riseEv | fallEv;
        endcase

        wrEn      = chipselect & ~write_n;
        clearMask = '0;
        irqMask_d = irqMask_q;
        if (wrEn && (address == ADDR_EDGECAP)) begin
            clearMask = writedata[WIDTH-1:0];
        end
        if (wrEn && (address == ADDR_IRQMASK)) begin
            irqMask_d = writedata[WIDTH-1:0];
        end
        edgeCap_d = (edgeCap_q & ~clearMask) | edgeEv;
    end

    // Read mux is sampled every cycle regardless of chipselect, giving one cycle of read latency
    always_comb begin
        readData_d = '0;
        case (address)
            ADDR_DATA:    readData_d[WIDTH-1:0] = stable_q;
            ADDR_IRQMASK: readData_d[WIDTH-1:0] = irqMask_q;
            ADDR_EDGECAP: readData_d[WIDTH-1:0] = edgeCap_q;
            default:      readData_d = '0;
        endcase
    end

    // Software-visible registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqMask_q  <= '0;
            edgeCap_q  <= '0;
            readData_q <= '0;
        end else begin
            irqMask_q  <= irqMask_d;
            edgeCap_q  <= edgeCap_d;
            readData_q <= readData_d;
        end
    end

    assign readdata = readData_q;
    assign irq      = |(edgeCap_q & irqMask_q);

endmodule

// File: tb/tb_de0qsys_button_pio.sv
// tb_de0qsys_button_pio
// Directed bench for the button PIO with a short debounce window (4 cycles) and any-edge capture.
// All expected values are hand-derived constants.

module tb_de0qsys_button_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rd;

    de0qsys_button_pio #(
        .WIDTH        (4),
        .DEBOUNCE_CYC (4),
        .EDGE_TYPE    (2),
        .IN_RST_VAL   (4'hF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    // 100 MHz bench clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock edge and settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Avalon write: one cycle with chipselect and write_n low
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
    endtask

    // Avalon read with one cycle of latency
    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        data       = readdata;
        chipselect = 1'b0;
        address    = 2'd0;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_port    = 4'hF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;

        $display("[TB] reset");
        waitCycles(5);
        checkOutput("rst_readdata", readdata, 32'h0);
        checkOutput("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        waitCycles(3);
        readReg(2'd0, rd);
        checkOutput("rst_data", rd, 32'h0000000F);

        $display("[TB] debounce glitch and timing");
        in_port = 4'hE;
        waitCycles(3);
        in_port = 4'hF;
        waitCycles(10);
        readReg(2'd0, rd);
        checkOutput("glitch_data", rd, 32'h0000000F);
        readReg(2'd3, rd);
        checkOutput("glitch_edgecap", rd, 32'h0);

        address = 2'd0;
        in_port = 4'hE;
        waitCycles(6);
        checkOutput("deb_not_yet", readdata, 32'h0000000F);
        tick();
        checkOutput("deb_exact", readdata, 32'h0000000E);
        waitCycles(3);
        in_port = 4'hF;
        waitCycles(10);
        checkOutput("deb_irq_masked", {31'b0, irq}, 32'h0);
        readReg(2'd3, rd);
        checkOutput("deb_edgecap", rd, 32'h00000001);
        applyStimulus(2'd3, 32'h1);
        readReg(2'd3, rd);
        checkOutput("deb_cleared", rd, 32'h0);

        $display("[TB] edge and irq");
        applyStimulus(2'd2, 32'h1);
        in_port = 4'hE;
        waitCycles(10);
        in_port = 4'hF;
        waitCycles(10);
        readReg(2'd3, rd);
        checkOutput("irq_edgecap", rd, 32'h00000001);
        checkOutput("irq_high", {31'b0, irq}, 32'h1);
        applyStimulus(2'd3, 32'h1);
        checkOutput("irq_cleared", {31'b0, irq}, 32'h0);
        readReg(2'd3, rd);
        checkOutput("irq_edgecap_clr", rd, 32'h0);

        $display("[TB] event versus clear race");
        in_port = 4'hB;
        waitCycles(6);
        applyStimulus(2'd3, 32'h4);
        readReg(2'd3, rd);
        checkOutput("race_event_wins", rd, 32'h00000004);
        applyStimulus(2'd3, 32'h0);
        readReg(2'd3, rd);
        checkOutput("race_w0_noeffect", rd, 32'h00000004);
        in_port = 4'hF;
        waitCycles(10);
        applyStimulus(2'd3, 32'h4);
        readReg(2'd3, rd);
        checkOutput("race_cleared", rd, 32'h0);

        $display("[TB] mask");
        applyStimulus(2'd2, 32'h0);
        in_port = 4'h7;
        waitCycles(10);
        in_port = 4'hF;
        waitCycles(10);
        checkOutput("mask_irq_low", {31'b0, irq}, 32'h0);
        applyStimulus(2'd2, 32'h8);
        checkOutput("mask_irq_high", {31'b0, irq}, 32'h1);
        readReg(2'd2, rd);
        checkOutput("mask_readback", rd, 32'h00000008);
        applyStimulus(2'd2, 32'hFFFFFFF0);
        readReg(2'd2, rd);
        checkOutput("mask_upper_ign", rd, 32'h0);
        checkOutput("mask_irq_off", {31'b0, irq}, 32'h0);
        readReg(2'd3, rd);
        checkOutput("mask_edgecap", rd, 32'h00000008);
        applyStimulus(2'd3, 32'h8);

        $display("[TB] reset mid-debounce");
        address = 2'd0;
        in_port = 4'hD;
        waitCycles(4);
        reset_n = 1'b0;
        tick();
        checkOutput("mid_rst_readdata", readdata, 32'h0);
        checkOutput("mid_rst_irq", {31'b0, irq}, 32'h0);
        tick();
        reset_n = 1'b1;
        waitCycles(6);
        checkOutput("mid_restart", readdata, 32'h0000000F);
        tick();
        checkOutput("mid_accept", readdata, 32'h0000000D);
        readReg(2'd2, rd);
        checkOutput("mid_irqmask", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
